// File: rtl/line_buffer_sched.sv
// Raster-position and bank-rotation sequencer for a 3-row line buffer with 4 rotating banks.
// Define LB_SCHED_ERR_EN to build the sticky protocol-error flag; otherwise err_out is tied low.
module line_buffer_sched #(
    parameter int HRES        = 1280,
    parameter int VRES        = 720,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        pixel_valid_in,
    input  logic                        sof_in,
    output logic [10:0]                 hcount_out,
    output logic [9:0]                  vcount_out,
    output logic                        we_out,
    output logic [1:0]                  wr_bank_out,
    output logic [KERNEL_SIZE-1:0][1:0] rd_bank_out,
    output logic                        window_valid_out,
    output logic [1:0]                  state_out,
    output logic                        frame_done_out,
    output logic                        err_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [10:0] H_LAST       = 11'(HRES - 1);
    localparam logic [9:0]  V_LAST       = 10'(VRES - 1);
    localparam logic [9:0]  V_PRIME_LAST = 10'(KERNEL_SIZE - 2);

    state_t      state, state_nxt, state_eff;
    logic [10:0] hcnt, hcnt_nxt, pos_h;
    logic [9:0]  vcnt, vcnt_nxt, pos_v;
    logic [1:0]  bank, bank_nxt, pos_b;
    logic        frame_done, frame_done_nxt;
    logic        restart, accept, line_end, frame_end;

    // A start-of-frame pixel is always pixel (0,0) of a priming frame, whatever the registers hold.
    always_comb begin
        restart   = pixel_valid_in && sof_in;
        accept    = pixel_valid_in && ((state != IDLE) || sof_in);
        state_eff = restart ? PRIME : state;
        pos_h     = restart ? 11'd0 : hcnt;
        pos_v     = restart ? 10'd0 : vcnt;
        pos_b     = restart ? 2'd0  : bank;
        line_end  = (pos_h == H_LAST);
        frame_end = line_end && (pos_v == V_LAST);
    end

    // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latch).
    always_comb begin
        hcnt_nxt       = hcnt;
        vcnt_nxt       = vcnt;
        bank_nxt       = bank;
        state_nxt      = state;
        frame_done_nxt = 1'b0;
        if (accept) begin
            if (frame_end) begin
                hcnt_nxt = 11'd0;
                vcnt_nxt = 10'd0;
                bank_nxt = 2'd0;
            end else if (line_end) begin
                hcnt_nxt = 11'd0;
                vcnt_nxt = pos_v + 10'd1;
                bank_nxt = pos_b + 2'd1;
            end else begin
                hcnt_nxt = pos_h + 11'd1;
                vcnt_nxt = pos_v;
                bank_nxt = pos_b;
            end

            unique case (state_eff)
                PRIME: begin
                    if (line_end && (pos_v == V_PRIME_LAST)) state_nxt = RUN;
                    else                                      state_nxt = PRIME;
                end
                RUN: begin
                    if (frame_end) begin
                        state_nxt      = IDLE;
                        frame_done_nxt = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = state_eff;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hcnt       <= 11'd0;
            vcnt       <= 10'd0;
            bank       <= 2'd0;
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            hcnt       <= hcnt_nxt;
            vcnt       <= vcnt_nxt;
            bank       <= bank_nxt;
            state      <= state_nxt;
            frame_done <= frame_done_nxt;
        end
    end

`ifdef LB_SCHED_ERR_EN
    logic err;
    logic err_set;

    // Restart while a frame is in flight, or stray pixels while idle, are both protocol faults.
    assign err_set = pixel_valid_in && (sof_in ? (state != IDLE) : (state == IDLE));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end

    assign err_out = err;
`else
    assign err_out = 1'b0;
`endif

    // Read banks are the three banks following the write bank, oldest row first.
    always_comb begin
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            rd_bank_out[k] = pos_b + 2'(k + 1);
        end
    end

    assign hcount_out       = pos_h;
    assign vcount_out       = pos_v;
    assign wr_bank_out      = pos_b;
    assign we_out           = accept;
    assign window_valid_out = accept && (state_eff == RUN);
    assign state_out        = state;
    assign frame_done_out   = frame_done;

endmodule

// File: doc/line_buffer_sched.md
# line_buffer_sched

Sequencer for the 3-row line buffer in the pixel pipeline. It tracks raster position from a start-of-frame-marked pixel stream and rotates the four row banks: one bank is written while three are read. It also withholds the window-valid flag until enough rows are primed, and flags malformed frames. It sits between the camera/pixel source and the line buffer and kernel stages, and replaces free-running per-bank counters with one frame-aware controller.

## Interface
- `HRES`, 1280, pixels per line.
- `VRES`, 720, lines per frame.
- `KERNEL_SIZE`, 3, rows per window; fixed at 3; bank count = `KERNEL_SIZE+1` = 4.

Ports:
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `pixel_valid_in`  in  1  pixel presented this cycle.
- `sof_in`  in  1  presented pixel is frame pixel (0,0); ignored unless `pixel_valid_in`.
- `hcount_out`  out  11  column of presented pixel.
- `vcount_out`  out  10  row of presented pixel.
- `we_out`  out  1  write presented pixel into bank `wr_bank_out`.
- `wr_bank_out`  out  2  bank being written.
- `rd_bank_out`  out  `[KERNEL_SIZE-1:0][1:0]`  read banks; index 0 = oldest row, index 2 = newest completed row.
- `window_valid_out`  out  1  presented pixel completes a valid 3-row window.
- `state_out`  out  2  0 IDLE, 1 PRIME, 2 RUN.
- `frame_done_out`  out  1  one-cycle pulse after last pixel of frame.
- `err_out`  out  1  sticky protocol error.

## Operation
- Registers: `hcnt`, `vcnt`, `bank`, `state`, `frame_done`, `err`.
- Accepted pixel: `pixel_valid_in && (state != IDLE || sof_in)`. A valid pixel without `sof_in` in IDLE is dropped: `we_out`=0 and counters hold.
- Position override: when `pixel_valid_in && sof_in`, the outputs show hcount=0, vcount=0, wr_bank=0 regardless of registers. Otherwise the outputs show `hcnt`/`vcnt`/`bank`.
- `we_out` = accepted pixel.
- `rd_bank_out[k]` = (`wr_bank_out` + 1 + k) mod 4.
- `window_valid_out` = accepted pixel && effective state RUN. The window's centre row is `vcount_out`-1.
- Counter update on an accepted pixel:
  - `hcnt` increments.
  - At `HRES-1`, `hcnt` wraps to 0, `vcnt` increments, and `bank` increments mod 4.
  - At (`HRES-1`,`VRES-1`), all counters go to 0 and `bank` goes to 0.
  - `sof_in` restarts from position (0,0), then advances as normal, so the next value is (1,0).
- State transitions (on accepted pixels only):
  - IDLE→PRIME on `sof_in`.
  - PRIME→RUN at the end of line `KERNEL_SIZE-2` (line 1).
  - RUN→IDLE at the end of line `VRES-1`, with `frame_done` set for the next cycle.
  - Any state→PRIME on `sof_in`; the sof pixel is at row 0.
- Arithmetic: counters are unsigned. `hcnt` never exceeds `HRES-1` and `vcnt` never exceeds `VRES-1`. Bank arithmetic is 2-bit modulo.

## Timing
- Position, bank and valid outputs are combinational from registers plus `pixel_valid_in`/`sof_in`, so zero latency for the same-cycle line buffer write.
- Register updates occur on the `clk_in` rising edge following an accepted pixel.
- `frame_done_out` is registered: high exactly 1 cycle after the last-pixel cycle, then low.
- Reset (async assert, sync-safe deassert assumed upstream): `hcnt`=0, `vcnt`=0, `bank`=0, state IDLE, `frame_done_out`=0, `err_out`=0. Outputs therefore show 0/0, `we_out`=0, `window_valid_out`=0 and `rd_bank_out`={1,2,3} while `pixel_valid_in`=0.
- Reset mid-frame: abandon the frame and wait for the next `sof_in`.
- Gaps (`pixel_valid_in`=0) may occur anywhere; all state holds across them.
- Simultaneous last pixel + `sof_in`: `sof_in` wins. This is a restart at (0,0), there is no `frame_done` pulse, and `err` is set (when enabled).

## Configuration
- `LB_SCHED_ERR_EN` defined:
  - `err_out` is set when `sof_in` arrives on a valid pixel while state != IDLE, or when a valid non-sof pixel arrives in IDLE.
  - It is cleared only by reset.
- Undefined: `err_out` is tied 0 and no error logic is built. Restart and drop behaviour is unchanged.

## Test plan
Use HRES=8, VRES=6.
- Reset: `rst_n_in`=0 -> all outputs 0, `rd_bank_out`={1,2,3}, state 0.
- Clean frame of 48 contiguous pixels with `sof_in` on the first -> `we_out` high 48 cycles; `wr_bank_out` 0,1,2,3,0,1 per line; `window_valid_out` low for the first 16 pixels and high for the remaining 32; `frame_done_out` pulses once, 1 cycle after pixel (7,5); state returns to 0.
- Pixels before `sof_in` in IDLE -> `we_out`=0 and counters hold; with `LB_SCHED_ERR_EN`, `err_out`=1.
- `sof_in` at pixel (3,4) of RUN -> that pixel shows (0,0) with bank 0; state goes to PRIME; no `frame_done_out` pulse; `err_out`=1 when enabled.
- Random `pixel_valid_in` gaps (50% duty) over a full frame -> identical (hcount, vcount, bank, window_valid) sequence on accepted pixels as the contiguous run.
- `rst_n_in` asserted at pixel (5,2) then a new `sof_in` -> the frame restarts at (0,0) with bank 0, and exactly one `frame_done_out` pulse at the end.
